mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NBITS, default 32, width of address and data buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch request; held high until if_done.
REQ-005 if_addr  input  NBITS  fetch address.
REQ-006 if_rdata  output  NBITS  fetched word, valid in the if_done cycle, held until the next fetch completes.
REQ-007 if_done  output  1  one-cycle pulse, fetch complete.
REQ-008 ls_req  input  1  load/store request; held high until ls_done.
REQ-009 ls_we  input  1  1 = store, 0 = load.
REQ-010 ls_addr  input  NBITS  data address.
REQ-011 ls_wdata  input  NBITS  store data.
REQ-012 ls_rdata  output  NBITS  load word, valid in the ls_done cycle, held until the next load completes.
REQ-013 ls_done  output  1  one-cycle pulse, load/store complete.
REQ-014 istall, dstall  output  1 each  stall to control unit: istall = if_req & ~if_done, and dstall = ls_req & ~ls_done.
REQ-015 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-016 mem_addr, mem_wdata  output  NBITS each  latched request address and write data.
REQ-017 mem_rdy  input  1  memory accepts the request when mem_req & mem_rdy.
REQ-018 mem_valid, mem_rdata  input  1 / NBITS  response strobe and read data; for writes, mem_valid is the acknowledgement.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-020 IDLE with an eligible request: pick the owner, latch addr/we/wdata, and go to ISSUE next cycle. For fetches, mem_we and mem_wdata are 0.
REQ-021 ISSUE: mem_req = 1; stay until mem_rdy = 1, then go to WAIT; the latched outputs stay stable throughout ISSUE.
REQ-022 WAIT: mem_req = 0; on mem_valid, register mem_rdata into the owner's rdata (loads/fetches only), pulse the owner's done the next cycle, and return to IDLE.
REQ-023 mem_valid outside WAIT is ignored.
REQ-024 Minimum latency is 3 cycles: req seen in IDLE at cycle 0, mem_req at cycle 1 with mem_rdy, mem_valid at cycle 2, done at cycle 3.
REQ-025 In the cycle the owner's done is high, that owner's req is masked and is not eligible for arbitration.
REQ-026 The other requester may be granted in the done cycle, so back-to-back transactions run with no idle gap.
REQ-027 Simultaneous if_req and ls_req in IDLE: ls wins (default fixed priority; see REQ-032).
REQ-028 A req that drops mid-transaction is ignored; the transaction completes and done still pulses.
REQ-029 A new request from the non-owner during ISSUE/WAIT waits, with its stall held high.

Reset
REQ-030 While rst = 0, the block is held in IDLE. mem_req, mem_we, if_done and ls_done are 0; mem_addr, mem_wdata, if_rdata and ls_rdata are 0; the round-robin pointer points to fetch.
REQ-031 Reset asserted mid-transaction aborts it: no done pulse, and any later mem_valid is ignored until a new ISSUE.

Configuration
REQ-032 Macro MEM_ARB_RR_EN selects the arbitration policy.
- Defined: round-robin. A 1-bit last-owner register is updated on every grant, and on a tie the requester not granted last wins.
- Undefined: fixed ls-over-if priority, and no pointer register exists.

Structure
REQ-033 Package mem_arb_pkg holds:
- typedef arb_state_t {IDLE, ISSUE, WAIT};
- typedef owner_t {OWN_IF, OWN_LS};
- the NBITS default constant.
REQ-034 One sub-module, arb_pick: combinational owner selection from the masked requests and the last owner; it contains the MEM_ARB_RR_EN logic.

Verification
REQ-035 Lone fetch: if_addr = 0x100, mem_rdy = 1, mem_valid one cycle after issue with rdata = 0xDEADBEEF -> if_done at cycle 3, if_rdata = 0xDEADBEEF, istall high during cycles 0-2.
REQ-036 Store: ls_we = 1, ls_addr = 0x2000, ls_wdata = 0x55 -> mem_we = 1, mem_addr = 0x2000, mem_wdata = 0x55; ls_done after mem_valid; ls_rdata unchanged.
REQ-037 Simultaneous requests, held continuously:
- MEM_ARB_RR_EN undefined: order ls, if, ls, ...
- MEM_ARB_RR_EN defined: alternating if/ls grants, if first after reset.
REQ-038 mem_rdy low for 4 cycles in ISSUE -> mem_req stays high with mem_addr stable; done latency becomes 7 cycles.
REQ-039 rst pulled low in WAIT, then mem_valid after release -> no done pulse, FSM in IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
`default_nettype none

package mem_arb_pkg;

  localparam int NBITS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t i_own);
    return (i_own == OWN_IF) ? OWN_LS : OWN_IF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational owner selection from masked requests.
// MEM_ARB_RR_EN defined -> round-robin tie break, else fixed ls-over-if priority.
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_ls_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t i_prio,
`endif
  output logic   o_grant,
  output owner_t o_owner
);

  always_comb begin
    o_grant = i_if_req | i_ls_req;
    o_owner = OWN_LS;
`ifdef MEM_ARB_RR_EN
    if (i_if_req && i_ls_req) begin
      o_owner = i_prio;
    end else if (i_if_req) begin
      o_owner = OWN_IF;
    end
`else
    if (i_if_req && !i_ls_req) begin
      o_owner = OWN_IF;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined.
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [NBITS-1:0] if_addr,
  output logic [NBITS-1:0] if_rdata,
  output logic             if_done,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [NBITS-1:0] ls_addr,
  input  logic [NBITS-1:0] ls_wdata,
  output logic [NBITS-1:0] ls_rdata,
  output logic             ls_done,
  output logic             istall,
  output logic             dstall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_rdy,
  input  logic             mem_valid,
  input  logic [NBITS-1:0] mem_rdata
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  owner_t           r_owner;
  logic             r_we;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_wdata;
  logic [NBITS-1:0] r_if_rdata;
  logic [NBITS-1:0] r_ls_rdata;
  logic             r_if_done;
  logic             r_ls_done;

  logic             w_if_elig;
  logic             w_ls_elig;
  logic             w_grant;
  owner_t           w_pick;
  logic             w_load;
  logic             w_complete;
  logic             w_mem_req;

  // A requester whose done is pulsing this cycle is still holding req; mask it.
  assign w_if_elig = if_req & ~r_if_done;
  assign w_ls_elig = ls_req & ~r_ls_done;

`ifdef MEM_ARB_RR_EN
  owner_t r_prio;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio <= OWN_IF;
    end else if (w_load) begin
      r_prio <= other_owner(w_pick);
    end
  end
`endif

  arb_pick u_pick (
    .i_if_req (w_if_elig),
    .i_ls_req (w_ls_elig),
`ifdef MEM_ARB_RR_EN
    .i_prio   (r_prio),
`endif
    .o_grant  (w_grant),
    .o_owner  (w_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_complete  = 1'b0;
    w_mem_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_mem_req = 1'b1;
        if (mem_rdy) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      if (w_load) begin
        r_owner <= w_pick;
        r_addr  <= (w_pick == OWN_LS) ? ls_addr : if_addr;
        r_we    <= (w_pick == OWN_LS) ? ls_we : 1'b0;
        r_wdata <= (w_pick == OWN_LS) ? ls_wdata : '0;
      end
      if (w_complete) begin
        if (r_owner == OWN_IF) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= mem_rdata;
        end else begin
          r_ls_done <= 1'b1;
          if (!r_we) begin
            r_ls_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_req   = w_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign if_done   = r_if_done;
  assign ls_done   = r_ls_done;
  assign istall    = if_req & ~r_if_done;
  assign dstall    = ls_req & ~r_ls_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        istall;
  logic        dstall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fail;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.NBITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_done   (ls_done),
    .istall    (istall),
    .dstall    (dstall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ls;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_rdy   = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);

    // Lone fetch, minimum latency
    cyc();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h100; mem_rdy = 1'b1;
    @(negedge clk);
    chk("f_c0_istall", istall, 1);
    chk("f_c0_mem_req", mem_req, 0);
    cyc();
    @(negedge clk);
    chk("f_c1_mem_req", mem_req, 1);
    chk("f_c1_mem_addr", mem_addr, 32'h100);
    chk("f_c1_mem_we", mem_we, 0);
    chk("f_c1_mem_wdata", mem_wdata, 0);
    chk("f_c1_istall", istall, 1);
    cyc();
    mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("f_c2_mem_req", mem_req, 0);
    chk("f_c2_if_done", if_done, 0);
    chk("f_c2_istall", istall, 1);
    cyc();
    mem_valid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("f_c3_if_done", if_done, 1);
    chk("f_c3_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_c3_istall", istall, 0);
    chk("f_c3_ls_done", ls_done, 0);
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("f_c4_if_done", if_done, 0);
    chk("f_c4_mem_req", mem_req, 0);

    // Store
    cyc();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'h55;
    @(negedge clk);
    chk("s_c0_dstall", dstall, 1);
    cyc();
    @(negedge clk);
    chk("s_c1_mem_req", mem_req, 1);
    chk("s_c1_mem_we", mem_we, 1);
    chk("s_c1_mem_addr", mem_addr, 32'h2000);
    chk("s_c1_mem_wdata", mem_wdata, 32'h55);
    cyc();
    mem_valid = 1'b1; mem_rdata = 32'h00000BAD;
    @(negedge clk);
    chk("s_c2_ls_done", ls_done, 0);
    cyc();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("s_c3_ls_done", ls_done, 1);
    chk("s_c3_ls_rdata", ls_rdata, 0);
    chk("s_c3_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("s_c3_dstall", dstall, 0);
    cyc();
    ls_req = 1'b0; ls_we = 1'b0;

    // Load whose request drops mid-transaction
    cyc();
    ls_req = 1'b1; ls_addr = 32'h50; ls_wdata = 32'h77;
    cyc();
    @(negedge clk);
    chk("l_c1_mem_we", mem_we, 0);
    chk("l_c1_mem_addr", mem_addr, 32'h50);
    cyc();
    ls_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0000CAFE;
    cyc();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("l_c3_ls_done", ls_done, 1);
    chk("l_c3_ls_rdata", ls_rdata, 32'h0000CAFE);
    chk("l_c3_dstall", dstall, 0);

    // mem_rdy low for 4 ISSUE cycles, spurious mem_valid during ISSUE
    cyc();
    if_req = 1'b1; if_addr = 32'h300; mem_rdy = 1'b0;
    cyc();
    @(negedge clk);
    chk("r_c1_mem_req", mem_req, 1);
    chk("r_c1_mem_addr", mem_addr, 32'h300);
    cyc();
    mem_valid = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("r_c2_mem_req", mem_req, 1);
    cyc();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("r_c3_mem_req", mem_req, 1);
    chk("r_c3_if_done", if_done, 0);
    cyc();
    @(negedge clk);
    chk("r_c4_mem_req", mem_req, 1);
    chk("r_c4_mem_addr", mem_addr, 32'h300);
    cyc();
    mem_rdy = 1'b1;
    @(negedge clk);
    chk("r_c5_mem_req", mem_req, 1);
    cyc();
    mem_valid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("r_c6_mem_req", mem_req, 0);
    chk("r_c6_if_done", if_done, 0);
    cyc();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("r_c7_if_done", if_done, 1);
    chk("r_c7_if_rdata", if_rdata, 32'h12345678);
    cyc();
    if_req = 1'b0;

    // Reset asserted in WAIT, late mem_valid after release
    cyc();
    if_req = 1'b1; if_addr = 32'h400;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("x_rst_mem_req", mem_req, 0);
    chk("x_rst_mem_addr", mem_addr, 0);
    chk("x_rst_if_rdata", if_rdata, 0);
    cyc();
    rst = 1'b1; if_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("x_rel_mem_req", mem_req, 0);
    cyc();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("x_post_if_done", if_done, 0);
    chk("x_post_if_rdata", if_rdata, 0);
    chk("x_post_mem_addr", mem_addr, 0);
    chk("x_post_mem_req", mem_req, 0);

    // Simultaneous requests held continuously
    cyc();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 32'hA0; ls_addr = 32'hB0; mem_rdy = 1'b1;
    @(negedge clk);
    chk("b_c0_istall", istall, 1);
    chk("b_c0_dstall", dstall, 1);
    for (int k = 0; k < 4; k++) begin
      exp_ls = RR ? (k % 2 == 1) : (k % 2 == 0);
      cyc();
      mem_valid = 1'b0;
      @(negedge clk);
      chk("b_issue_mem_req", mem_req, 1);
      chk("b_issue_mem_addr", mem_addr, exp_ls ? 32'hB0 : 32'hA0);
      chk("b_issue_other_stall", exp_ls ? istall : dstall, 1);
      cyc();
      mem_valid = 1'b1; mem_rdata = 32'h1000 + k;
      @(negedge clk);
      chk("b_wait_mem_req", mem_req, 0);
      cyc();
      mem_valid = 1'b0;
      @(negedge clk);
      chk("b_done_owner", exp_ls ? ls_done : if_done, 1);
      chk("b_done_other", exp_ls ? if_done : ls_done, 0);
      chk("b_done_rdata", exp_ls ? ls_rdata : if_rdata, 32'h1000 + k);
    end
    cyc();
    if_req = 1'b0; ls_req = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
